// File: rtl/instr_encoder_pkg.sv
// Shared opcodes, descriptor class and FSM state types, plus the RV32I
// field-placement and immediate range helpers used by instr_encoder.
package instr_encoder_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_U  = 7'b0110111;
  localparam logic [6:0] OP_J  = 7'b1101111;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_U   = 3'd5,
    CLS_J   = 3'd6,
    CLS_ILL = 3'd7
  } cls_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] encode(input cls_t        cls,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [2:0]  f3,
                                         input logic [6:0]  f7,
                                         input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (cls)
      CLS_R:  w = {f7, rs2, rs1, f3, rd, OP_R};
      CLS_I:  w = {imm[11:0], rs1, f3, rd, OP_I};
      CLS_LW: w = {imm[11:0], rs1, f3, rd, OP_LW};
      CLS_SW: w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_SW};
      CLS_BR: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
      CLS_U:  w = {imm[31:12], rd, OP_U};
      CLS_J:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Branch/jump offsets must also be even since bit 0 is not encodable.
  function automatic logic imm_out_of_range(input cls_t               cls,
                                            input logic signed [31:0] imm);
    logic bad;
    bad = 1'b0;
    case (cls)
      CLS_I, CLS_LW, CLS_SW:
        bad = (imm < -32'sd2048) || (imm > 32'sd2047);
      CLS_BR:
        bad = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
      CLS_J:
        bad = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
      CLS_U:
        bad = (imm[11:0] != 12'd0);
      default:
        bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Output word buffer for instr_encoder: DEPTH x 32-bit, power-of-two depth,
// push is accepted while full if a pop happens in the same cycle.
module enc_fifo
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic [31:0] i_data,
  input  logic        i_pop,
  output logic [31:0] o_data,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage is data only; validity is tracked entirely by r_cnt.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction descriptors into RV32I words and streams them into
// instruction memory. Optional macro: INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [2:0]        i_in_class,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [2:0]        i_in_funct3,
  input  logic [6:0]        i_in_funct7,
  input  logic [31:0]       i_in_imm,
  output logic              o_wr_en,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_acc_cnt;
  logic [CNT_W-1:0]  r_fin_cnt;
  logic [CNT_W-1:0]  w_fin_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_err;

  cls_t        w_cls;
  logic        w_bad;
  logic        w_accept;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic        w_start_ok;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_enc;
  logic [31:0] w_head;

  assign w_cls = cls_t'(i_in_class);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign w_bad = (w_cls == CLS_ILL) | imm_out_of_range(w_cls, i_in_imm);
`else
  assign w_bad = (w_cls == CLS_ILL);
`endif

  assign w_enc = encode(w_cls, i_in_rd, i_in_rs1, i_in_rs2,
                        i_in_funct3, i_in_funct7, i_in_imm);

  assign o_in_ready = (r_state == ST_LOAD) & ~w_full & (r_acc_cnt < r_len);
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_drop     = w_accept & w_bad;
  assign w_push     = w_accept & ~w_bad;
  assign w_pop      = o_wr_en & i_wr_ready;
  assign w_start_ok = i_start & (r_state == ST_IDLE);

  // Written and dropped descriptors both retire a slot of the session.
  assign w_fin_nxt = r_fin_cnt + CNT_W'(w_pop) + CNT_W'(w_drop);

  enc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_enc),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_wr_en   = ~w_empty;
  assign o_wr_data = w_empty ? 32'd0 : w_head;
  assign o_wr_addr = r_wr_addr;
  assign o_err     = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = (i_len == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        o_busy = 1'b1;
        if (w_fin_nxt == r_len) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len     <= '0;
      r_acc_cnt <= '0;
      r_fin_cnt <= '0;
      r_wr_addr <= '0;
      r_err     <= 1'b0;
    end else if (w_start_ok) begin
      r_len     <= i_len;
      r_acc_cnt <= '0;
      r_fin_cnt <= '0;
      r_wr_addr <= i_base_addr;
      r_err     <= 1'b0;
    end else begin
      if (w_accept)             r_acc_cnt <= r_acc_cnt + 1'b1;
      if (r_state == ST_LOAD)   r_fin_cnt <= w_fin_nxt;
      if (w_pop)                r_wr_addr <= r_wr_addr + 1'b1;
      if (w_drop)               r_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// sessions against an arithmetic reference model of the RV32I formats.
module tb_instr_encoder;

  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_class = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic [6:0]        in_funct7 = '0;
  logic [31:0]       in_imm = '0;
  logic              wr_en;
  logic              wr_ready = 1'b1;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy, done, err;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_len(len), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_class(in_class), .i_in_rd(in_rd), .i_in_rs1(in_rs1),
    .i_in_rs2(in_rs2), .i_in_funct3(in_funct3), .i_in_funct7(in_funct7),
    .i_in_imm(in_imm), .o_wr_en(wr_en), .i_wr_ready(wr_ready),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy), .o_done(done),
    .o_err(err)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } desc_t;

  desc_t             stim[$];
  logic [31:0]       exp_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  bit                exp_err;
  logic [31:0]       got_data[$];
  logic [ADDR_W-1:0] got_addr[$];
  int                n_pass = 0;
  int                n_total = 0;

  // A write completes on the next rising edge when both are high mid-cycle.
  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ready) begin
      got_data.push_back(wr_data);
      got_addr.push_back(wr_addr);
    end
  end

  function automatic desc_t mk(int c, int rd, int rs1, int rs2, int f3, int f7, int imm);
    desc_t d;
    logic [31:0] v;
    v = c;   d.cls = v[2:0];
    v = rd;  d.rd  = v[4:0];
    v = rs1; d.rs1 = v[4:0];
    v = rs2; d.rs2 = v[4:0];
    v = f3;  d.f3  = v[2:0];
    v = f7;  d.f7  = v[6:0];
    d.imm = imm;
    return d;
  endfunction

  function automatic bit model_bad(desc_t d);
    int s;
    s = $signed(d.imm);
    if (d.cls == 3'd7) return 1'b1;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    if (d.cls == 3'd1 || d.cls == 3'd2 || d.cls == 3'd3) return (s < -2048 || s > 2047);
    if (d.cls == 3'd4) return (s < -4096 || s > 4094 || (s % 2) != 0);
    if (d.cls == 3'd6) return (s < -1048576 || s > 1048574 || (s % 2) != 0);
    if (d.cls == 3'd5) return (d.imm % 4096) != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_word(desc_t d);
    int unsigned imm, rd, rs1, rs2, f3, f7, w;
    imm = d.imm; rd = d.rd; rs1 = d.rs1; rs2 = d.rs2; f3 = d.f3; f7 = d.f7;
    w = 0;
    case (d.cls)
      3'd0: w = 51 + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 + f7 * 33554432;
      3'd1: w = 19 + rd * 128 + f3 * 4096 + rs1 * 32768 + (imm % 4096) * 1048576;
      3'd2: w =  3 + rd * 128 + f3 * 4096 + rs1 * 32768 + (imm % 4096) * 1048576;
      3'd3: w = 35 + (imm % 32) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576
                + ((imm / 32) % 128) * 33554432;
      3'd4: w = 99 + ((imm / 2048) % 2) * 128 + ((imm / 2) % 16) * 256 + f3 * 4096
                + rs1 * 32768 + rs2 * 1048576 + ((imm / 32) % 64) * 33554432
                + ((imm / 4096) % 2) * 32'h8000_0000;
      3'd5: w = 55 + rd * 128 + (imm - (imm % 4096));
      3'd6: w = 111 + rd * 128 + ((imm / 4096) % 256) * 4096 + ((imm / 2048) % 2) * 1048576
                + ((imm / 2) % 1024) * 2097152 + ((imm / 1048576) % 2) * 32'h8000_0000;
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic build_expected(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    a = base;
    exp_data.delete(); exp_addr.delete(); exp_err = 1'b0;
    foreach (stim[k]) begin
      if (model_bad(stim[k])) exp_err = 1'b1;
      else begin
        exp_data.push_back(model_word(stim[k]));
        exp_addr.push_back(a);
        a = a + 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic present(desc_t d);
    in_class = d.cls; in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2;
    in_funct3 = d.f3; in_funct7 = d.f7; in_imm = d.imm;
  endtask

  task automatic start_sess(input logic [ADDR_W-1:0] b, input int n);
    got_data.delete(); got_addr.delete();
    base_addr = b; len = n[ADDR_W:0]; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic drive_stim(input int from, output bit ok);
    bit acc;
    ok = 1'b1;
    for (int k = from; k < stim.size(); k++) begin
      present(stim[k]);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (in_ready) acc = 1'b1;
        @(posedge clk); #1;
        if (acc) break;
      end
      if (!acc) begin ok = 1'b0; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else n_pass++;
    n_total++; if (wr_addr !== '0 || wr_data !== '0) $display("FAIL reset_wr_bus got %h/%h want 0/0", wr_addr, wr_data); else n_pass++;
    n_total++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_status got %b want 000", {busy, done, err}); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_r_single();
    bit ok;
    stim.delete(); stim.push_back(mk(0, 3, 1, 2, 0, 0, 0));
    start_sess(8'h10, 1);
    n_total++; if (busy !== 1'b1) $display("FAIL r_busy got %b want 1", busy); else n_pass++;
    drive_stim(0, ok);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL r_done got timeout want done pulse"); else n_pass++;
    n_total++; if (got_data.size() != 1) $display("FAIL r_count got %0d want 1", got_data.size()); else n_pass++;
    if (got_data.size() > 0) begin
      n_total++;
      if (got_data[0] !== 32'h002081B3 || got_addr[0] !== 8'h10)
        $display("FAIL r_word got %h@%h want 002081b3@10", got_data[0], got_addr[0]);
      else n_pass++;
    end
    cyc();
    n_total++; if ({busy, done} !== 2'b00) $display("FAIL r_pulse got %b want 00", {busy, done}); else n_pass++;
  endtask

  task automatic test_lw_br();
    bit ok;
    stim.delete();
    stim.push_back(mk(2, 5, 2, 0, 2, 0, 8));
    stim.push_back(mk(4, 0, 1, 2, 0, 0, -4));
    start_sess(8'h40, 2);
    drive_stim(0, ok);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL lwbr_done got timeout want done"); else n_pass++;
    n_total++; if (got_data.size() != 2) $display("FAIL lwbr_count got %0d want 2", got_data.size()); else n_pass++;
    if (got_data.size() == 2) begin
      n_total++;
      if (got_data[0] !== 32'h00812283 || got_addr[0] !== 8'h40)
        $display("FAIL lw_word got %h@%h want 00812283@40", got_data[0], got_addr[0]);
      else n_pass++;
      n_total++;
      if (got_data[1] !== 32'hFE208EE3 || got_addr[1] !== 8'h41)
        $display("FAIL br_word got %h@%h want fe208ee3@41", got_data[1], got_addr[1]);
      else n_pass++;
    end
    cyc();
  endtask

  task automatic test_wrap();
    bit ok;
    stim.delete();
    stim.push_back(mk(6, 1, 0, 0, 0, 0, 8));
    stim.push_back(mk(1, 2, 3, 0, 0, 0, 1));
    start_sess(8'hFF, 2);
    drive_stim(0, ok);
    wait_done(ok);
    n_total++; if (got_data.size() != 2) $display("FAIL wrap_count got %0d want 2", got_data.size()); else n_pass++;
    if (got_data.size() == 2) begin
      n_total++;
      if (got_data[0] !== 32'h008000EF || got_addr[0] !== 8'hFF)
        $display("FAIL j_word got %h@%h want 008000ef@ff", got_data[0], got_addr[0]);
      else n_pass++;
      n_total++; if (got_addr[1] !== 8'h00) $display("FAIL wrap_addr got %h want 00", got_addr[1]); else n_pass++;
    end
    cyc();
  endtask

  task automatic test_back_to_back_stall();
    bit ok, acc, seen, unstable;
    int idx;
    logic [31:0] held;
    stim.delete();
    for (int k = 0; k < 6; k++) stim.push_back(mk(0, k + 1, k + 2, k + 3, k, k * 9, 0));
    wr_ready = 1'b0;
    start_sess(8'h80, 6);
    idx = 0; seen = 1'b0; unstable = 1'b0; held = '0;
    for (int c = 0; c < 8; c++) begin
      present(stim[idx < 6 ? idx : 5]);
      in_valid = (idx < 6);
      @(negedge clk);
      acc = in_ready;
      if (wr_en) begin
        if (!seen) begin held = wr_data; seen = 1'b1; end
        else if (wr_data !== held) unstable = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    n_total++; if (idx != FIFO_DEPTH) $display("FAIL stall_accepted got %0d want %0d", idx, FIFO_DEPTH); else n_pass++;
    n_total++; if (in_ready !== 1'b0 || wr_en !== 1'b1) $display("FAIL stall_flags got rdy=%b en=%b want 0/1", in_ready, wr_en); else n_pass++;
    n_total++; if (unstable || wr_data !== model_word(stim[0])) $display("FAIL stall_hold got %h want %h", wr_data, model_word(stim[0])); else n_pass++;
    n_total++; if (got_data.size() != 0) $display("FAIL stall_nowrite got %0d want 0", got_data.size()); else n_pass++;
    wr_ready = 1'b1;
    drive_stim(idx, ok);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL stall_done got timeout want done"); else n_pass++;
    build_expected(8'h80);
    n_total++; if (got_data.size() != exp_data.size()) $display("FAIL stall_count got %0d want %0d", got_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i])
        $display("FAIL stall_word%0d got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      else n_pass++;
    end
    cyc();
  endtask

  task automatic test_illegal();
    bit ok;
    stim.delete();
    stim.push_back(mk(0, 4, 5, 6, 1, 0, 0));
    stim.push_back(mk(7, 1, 1, 1, 1, 1, 0));
    stim.push_back(mk(1, 7, 8, 0, 3, 0, -1));
    start_sess(8'h20, 3);
    drive_stim(0, ok);
    n_total++; if (in_ready !== 1'b0) $display("FAIL ill_ready_after_len got %b want 0", in_ready); else n_pass++;
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL ill_done got timeout want done"); else n_pass++;
    build_expected(8'h20);
    n_total++; if (got_data.size() != exp_data.size()) $display("FAIL ill_count got %0d want %0d", got_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i])
        $display("FAIL ill_word%0d got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      else n_pass++;
    end
    repeat (3) cyc();
    n_total++; if (err !== 1'b1) $display("FAIL ill_err_sticky got %b want 1", err); else n_pass++;
    start_sess(8'h00, 0);
    n_total++; if (err !== 1'b0) $display("FAIL err_clear got %b want 0", err); else n_pass++;
    wait_done(ok);
    n_total++; if (!ok || busy !== 1'b0) $display("FAIL empty_session got ok=%b busy=%b want 1/0", ok, busy); else n_pass++;
    n_total++; if (got_data.size() != 0) $display("FAIL empty_writes got %0d want 0", got_data.size()); else n_pass++;
    cyc();
  endtask

  task automatic test_range();
    bit ok;
    stim.delete();
    stim.push_back(mk(1, 1, 2, 0, 0, 0, 3000));
    stim.push_back(mk(0, 3, 1, 2, 0, 0, 0));
    start_sess(8'h30, 2);
    drive_stim(0, ok);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL range_done got timeout want done"); else n_pass++;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    n_total++; if (got_data.size() != 1 || err !== 1'b1) $display("FAIL range_drop got n=%0d err=%b want 1/1", got_data.size(), err); else n_pass++;
`else
    n_total++; if (got_data.size() != 2 || err !== 1'b0) $display("FAIL range_trunc got n=%0d err=%b want 2/0", got_data.size(), err); else n_pass++;
    if (got_data.size() > 0) begin
      n_total++; if (got_data[0][31:20] !== 12'hBB8) $display("FAIL range_imm got %h want bb8xxxxx", got_data[0]); else n_pass++;
    end
`endif
    cyc();
  endtask

  task automatic test_random();
    bit ok_d, ok_w, stop;
    int n;
    logic [ADDR_W-1:0] b;
    for (int s = 0; s < 6; s++) begin
      stim.delete();
      n = $urandom_range(1, 10);
      b = $urandom_range(0, 255);
      for (int k = 0; k < n; k++) begin
        int c, imm;
        c = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
        imm = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 10000)) - 5000;
        stim.push_back(mk(c, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 7), $urandom_range(0, 127), imm));
      end
      build_expected(b);
      start_sess(b, n);
      stop = 1'b0;
      fork
        begin drive_stim(0, ok_d); wait_done(ok_w); stop = 1'b1; end
        begin
          while (!stop) begin wr_ready = ($urandom_range(0, 3) != 0); cyc(); end
          wr_ready = 1'b1;
        end
      join
      n_total++; if (!ok_d || !ok_w) $display("FAIL rnd%0d_progress got drive=%b done=%b want 1/1", s, ok_d, ok_w); else n_pass++;
      n_total++; if (got_data.size() != exp_data.size()) $display("FAIL rnd%0d_count got %0d want %0d", s, got_data.size(), exp_data.size()); else n_pass++;
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
        n_total++;
        if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i])
          $display("FAIL rnd%0d_word%0d got %h@%h want %h@%h", s, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        else n_pass++;
      end
      n_total++; if (err !== exp_err) $display("FAIL rnd%0d_err got %b want %b", s, err, exp_err); else n_pass++;
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    stim.delete();
    for (int k = 0; k < 3; k++) stim.push_back(mk(1, k + 1, 0, 0, 0, 0, k + 5));
    wr_ready = 1'b0;
    start_sess(8'h50, 5);
    drive_stim(0, ok);
    n_total++; if (!ok || wr_en !== 1'b1) $display("FAIL rstmid_buffered got ok=%b en=%b want 1/1", ok, wr_en); else n_pass++;
    rst_n = 1'b0; wr_ready = 1'b1;
    #1;
    n_total++; if (wr_en !== 1'b0 || wr_data !== '0 || wr_addr !== '0) $display("FAIL rstmid_outputs got en=%b data=%h addr=%h want 0", wr_en, wr_data, wr_addr); else n_pass++;
    n_total++; if ({busy, done, err, in_ready} !== 4'b0000) $display("FAIL rstmid_status got %b want 0000", {busy, done, err, in_ready}); else n_pass++;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    n_total++; if (got_data.size() != 0) $display("FAIL rstmid_nowrite got %0d want 0", got_data.size()); else n_pass++;
    n_total++; if ({busy, done, wr_en} !== 3'b000) $display("FAIL rstmid_idle got %b want 000", {busy, done, wr_en}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_r_single();
    test_lw_br();
    test_wrap();
    test_back_to_back_stall();
    test_illegal();
    test_range();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, 8, instruction-memory word-address width.
REQ-002 Parameter FIFO_DEPTH, 4, output buffer entries (power of two, >=2).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse: begin a load session.
REQ-006 base_addr  in  ADDR_W  first word address, sampled on start.
REQ-007 len  in  ADDR_W+1  words to write this session, sampled on start; 0 = empty session.
REQ-008 in_valid / in_ready  in / out  1 / 1  descriptor handshake.
REQ-009 in_class  in  3  0=R, 1=I, 2=LW, 3=SW, 4=BR, 5=U, 6=J, 7=illegal.
REQ-010 in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-011 in_funct3 / in_funct7  in  3 / 7  function fields; funct7 used only for R.
REQ-012 in_imm  in  32  signed byte-offset immediate (U: full 32-bit value).
REQ-013 wr_en / wr_ready  out / in  1 / 1  imem write handshake; write occurs when both high.
REQ-014 wr_addr / wr_data  out  ADDR_W / 32  write address and RV32I instruction word.
REQ-015 busy / done / err  out  1 each  session active; one-cycle completion pulse; sticky error.

Function
REQ-016 FSM states IDLE, LOAD, DONE; IDLE->LOAD on start (len!=0), IDLE->DONE on start with len==0, LOAD->DONE when len words written, DONE->IDLE next cycle unconditionally.
REQ-017 start outside IDLE is ignored.
REQ-018 busy SHALL be 1 in LOAD only; done SHALL be 1 in DONE only.
REQ-019 in_ready = (state==LOAD) & FIFO not full & accepted-count < len; descriptor accepted when in_valid & in_ready.
REQ-020 Encoding combinational from descriptor, pushed to FIFO on acceptance; word on wr_data earliest one cycle after acceptance.
REQ-021 Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, U 0110111, J 1101111.
REQ-022 Field placement per RV32I R/I/S/B/U/J formats; B and J use imm[12:1] and imm[20:1], bit 0 discarded.
REQ-023 in_class 7 SHALL set err and be consumed without FIFO push, counting toward len.
REQ-024 wr_en = FIFO not empty; wr_addr starts at base_addr, increments by 1 per completed write, wraps modulo 2^ADDR_W.
REQ-025 Simultaneous push and pop with FIFO full or empty SHALL both succeed with no loss or duplication.
REQ-026 wr_ready low holds wr_en, wr_addr, wr_data stable.
REQ-027 Session completes when written-plus-dropped count equals len; FIFO empty on entry to DONE.
REQ-028 err clears only on reset or on start accepted in IDLE.

Reset
REQ-029 reset low SHALL immediately force IDLE, empty FIFO, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, counters=0.
REQ-030 Reset mid-session discards buffered words; no write completes after reset asserts.

Configuration
REQ-031 Macro INSTR_ENCODER_RANGE_CHECK_EN defined: out-of-range immediate (I/LW/SW outside [-2048,2047]; BR outside [-4096,4094] or odd; J outside [-2^20,2^20-2] or odd; U with imm[11:0]!=0) sets err, descriptor consumed and dropped as REQ-023.
REQ-032 Macro undefined: immediates silently truncated, err set only by class 7.

Structure
REQ-033 Package instr_encoder_pkg SHALL hold the seven opcode localparams, the class enum, and the FSM state enum.
REQ-034 Output buffer SHALL be sub-module enc_fifo (parameter DEPTH, 32-bit data, full/empty flags).

Verification
REQ-035 start base=0x10 len=1; R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> write 0x002081B3 @0x10, done pulse.
REQ-036 LW rd=5 rs1=2 f3=2 imm=8, then BR rs1=1 rs2=2 f3=0 imm=-4 -> 0x00812283 @base, 0xFE208EE3 @base+1.
REQ-037 J rd=1 imm=8 at base=0xFF -> 0x008000EF @0xFF; next word @0x00 (wrap).
REQ-038 wr_ready=0 for 8 cycles, 6 descriptors offered -> exactly 4 accepted, in_ready=0, wr_data held stable; on release all 6 written in order.
REQ-039 With macro, I imm=3000 in len=2 session -> err=1, one word written, done after second descriptor; without macro -> word 0xBB8xxxxx written, err=0.
REQ-040 reset asserted with 3 words buffered -> wr_en=0 same cycle, no further writes, state IDLE.
